rca4_checker: RTL and testbench
===============================

RCA4_CHECKER -- requirements
Module: rca4_checker

Interface
REQ-001 Parameter WIDTH, default 4: adder operand width under test.
REQ-002 Parameter SETTLE, default 2: wait cycles between driving a vector and sampling the result; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  run request; sampled only in IDLE or DONE.
REQ-006 dut_a  output  WIDTH  operand A driven to the adder under test (registered).
REQ-007 dut_b  output  WIDTH  operand B driven to the adder under test (registered).
REQ-008 dut_ci  output  1  carry-in driven to the adder under test (registered).
REQ-009 dut_s  input  WIDTH  sum returned by the adder under test.
REQ-010 dut_co  input  1  carry-out returned by the adder under test.
REQ-011 busy  output  1  high from the first DRIVE cycle until DONE is entered.
REQ-012 done  output  1  high while in DONE; held until the next start or reset.
REQ-013 pass  output  1  valid while done=1; 1 iff err_cnt=0.
REQ-014 err_cnt  output  2*WIDTH+2  number of mismatching vectors in the current or last run.
REQ-015 fail_vec  output  2*WIDTH+1  first failing vector {a,b,ci}; 0 if none.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-017 The vector counter vec SHALL be 2*WIDTH+1 bits, with a=vec[2W:W+1], b=vec[W:1] and ci=vec[0]; it SHALL step from 0 to all-ones in ascending order, giving 512 vectors for WIDTH=4.
REQ-018 In IDLE or DONE, start=1 SHALL clear vec, err_cnt, fail_vec and the first-fail flag, and SHALL enter DRIVE on the next edge.
REQ-019 DRIVE SHALL last 1 cycle, register vec onto dut_a/dut_b/dut_ci, and then go to WAIT (SETTLE>0) or CHECK (SETTLE=0).
REQ-020 WAIT SHALL last exactly SETTLE cycles, counted by a settle counter, and then go to CHECK.
REQ-021 CHECK SHALL last 1 cycle and compare {dut_co,dut_s} against the expected dut_a+dut_b+dut_ci, computed at WIDTH+1 bits.
REQ-022 On a mismatch, err_cnt SHALL increment; no saturation is needed because the width covers all 2^(2W+1) vectors.
REQ-023 On the first mismatch of a run, fail_vec SHALL capture vec; later mismatches SHALL leave fail_vec unchanged.
REQ-024 After CHECK, if vec is all-ones the FSM SHALL enter DONE; otherwise vec SHALL increment and the FSM SHALL return to DRIVE.
REQ-025 Per-vector cost SHALL be SETTLE+2 cycles, and done SHALL rise exactly 1+2^(2W+1)*(SETTLE+2) cycles after the edge that samples start (2049 cycles for the defaults).
REQ-026 start SHALL be ignored while busy=1.
REQ-027 The mismatch increment and the final-vector transition to DONE SHALL both take effect at the same edge; the final err_cnt SHALL be visible in the first cycle that done=1.
REQ-028 dut_* outputs SHALL hold their last vector in DONE and IDLE.

Reset
REQ-029 reset_n=0 SHALL force IDLE immediately, including mid-run, regardless of clk.
REQ-030 During reset, dut_a, dut_b, dut_ci, busy, done, pass, err_cnt, fail_vec, vec and the settle counter SHALL all be 0.
REQ-031 After reset release, the block SHALL stay in IDLE until start=1.

Structure
REQ-032 The FSM state encoding and the SETTLE maximum SHALL live in a shared package, rca4_pkg.
REQ-033 The golden reference adder SHALL be a single behavioural sub-module, rca4_model, with no dependency on the design under test.
REQ-034 All other logic (FSM, counters, compare) SHALL stay in rca4_checker.

Verification
REQ-035 Correct 4-bit RCA, SETTLE=2, start pulse -> done after 2049 cycles, pass=1, err_cnt=0, fail_vec=0.
REQ-036 Adder with dut_co stuck at 0 -> err_cnt=256, fail_vec=0x1F (a=0,b=15,ci=1), pass=0.
REQ-037 Adder with dut_s[0] inverted -> err_cnt=512, fail_vec=0x000, pass=0.
REQ-038 Correct adder, reset_n pulsed low mid-run (vec=100) -> all outputs 0 asynchronously and state IDLE; a new start -> full clean run, pass=1.
REQ-039 start held high for the whole run -> exactly one run while busy, then restart from DONE with err_cnt cleared.
REQ-040 SETTLE=0, correct adder -> done after 1+512*2=1025 cycles, pass=1.

Source files
------------

// File: rtl/rca4_pkg.sv
// rtl/rca4_pkg.sv - shared FSM encoding and settle limits for the RCA checker
package rca4_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_DRIVE = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
   localparam logic [STATE_W-1:0] ST_CHECK = 3'd3;
   localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

   localparam int SETTLE_W   = 4;
   localparam int SETTLE_MAX = 15;

   // Terminal value of the settle counter; WAIT is never entered when settle is 0.
   function automatic logic [SETTLE_W-1:0] settle_last(input int settle);
      if (settle <= 0) return '0;
      return SETTLE_W'(settle - 1);
   endfunction

endpackage

// File: rtl/rca4_model.sv
// rtl/rca4_model.sv - behavioural golden adder, independent of the adder under test
module rca4_model #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH:0]   sum
);

   assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/rca4_checker.sv
// rtl/rca4_checker.sv - exhaustive sweep checker for an external ripple-carry adder
module rca4_checker
   import rca4_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   output logic                 dut_ci,
   input  logic [WIDTH-1:0]     dut_s,
   input  logic                 dut_co,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH+1:0]   err_cnt,
   output logic [2*WIDTH:0]     fail_vec
);

   localparam int VW       = 2 * WIDTH + 1;
   localparam int SETTLE_C = (SETTLE > SETTLE_MAX) ? SETTLE_MAX : ((SETTLE < 0) ? 0 : SETTLE);
   localparam logic [SETTLE_W-1:0] SETTLE_END = settle_last(SETTLE_C);

   logic [STATE_W-1:0]  state;
   logic [VW-1:0]       vec;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                failed;
   logic                armed;
   logic [WIDTH:0]      expected;
   logic                mismatch;

   rca4_model #(.WIDTH(WIDTH)) u_model (
      .a   (dut_a),
      .b   (dut_b),
      .ci  (dut_ci),
      .sum (expected)
   );

   assign mismatch = ({dut_co, dut_s} != expected);
   assign busy     = (state == ST_DRIVE) || (state == ST_WAIT) || (state == ST_CHECK);
   assign done     = (state == ST_DONE);
   assign pass     = done && (err_cnt == '0);

   // A sampled start clears the run state and arms IDLE; the armed cycle then launches DRIVE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         dut_a      <= '0;
         dut_b      <= '0;
         dut_ci     <= 1'b0;
         err_cnt    <= '0;
         fail_vec   <= '0;
         failed     <= 1'b0;
         armed      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (armed) begin
                  armed <= 1'b0;
                  state <= ST_DRIVE;
               end else if (start) begin
                  vec      <= '0;
                  err_cnt  <= '0;
                  fail_vec <= '0;
                  failed   <= 1'b0;
                  armed    <= 1'b1;
               end
            end
            ST_DONE: begin
               if (start) begin
                  vec      <= '0;
                  err_cnt  <= '0;
                  fail_vec <= '0;
                  failed   <= 1'b0;
                  armed    <= 1'b1;
                  state    <= ST_IDLE;
               end
            end
            ST_DRIVE: begin
               dut_a      <= vec[VW-1:WIDTH+1];
               dut_b      <= vec[WIDTH:1];
               dut_ci     <= vec[0];
               settle_cnt <= '0;
               state      <= (SETTLE_C == 0) ? ST_CHECK : ST_WAIT;
            end
            ST_WAIT: begin
               if (settle_cnt == SETTLE_END) begin
                  state <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  err_cnt <= err_cnt + 1'b1;
                  if (!failed) begin
                     fail_vec <= vec;
                     failed   <= 1'b1;
                  end
               end
               if (&vec) begin
                  state <= ST_DONE;
               end else begin
                  vec   <= vec + 1'b1;
                  state <= ST_DRIVE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rca4_checker.sv
// tb/tb_rca4_checker.sv - directed self-checking bench for rca4_checker
module tb_rca4_checker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       start0;
   logic [3:0] dut_a, dut_b, a0, b0;
   logic       dut_ci, ci0;
   logic [3:0] dut_s, s0;
   logic       dut_co, co0;
   logic       busy, done, pass, busy0, done0, pass0;
   logic [9:0] err_cnt, err_cnt0;
   logic [8:0] fail_vec, fail_vec0;
   int         mode;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   // Adder under test: 0 = correct, 1 = carry-out stuck at 0, 2 = sum bit 0 inverted.
   logic [4:0] full_sum;
   always_comb begin
      full_sum = {1'b0, dut_a} + {1'b0, dut_b} + {4'b0, dut_ci};
      dut_s    = full_sum[3:0];
      dut_co   = full_sum[4];
      if (mode == 1) dut_co = 1'b0;
      if (mode == 2) dut_s[0] = ~full_sum[0];
   end
   assign {co0, s0} = {1'b0, a0} + {1'b0, b0} + {4'b0, ci0};

   rca4_checker #(.WIDTH(4), .SETTLE(2)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .dut_a(dut_a), .dut_b(dut_b), .dut_ci(dut_ci),
      .dut_s(dut_s), .dut_co(dut_co),
      .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .fail_vec(fail_vec)
   );

   rca4_checker #(.WIDTH(4), .SETTLE(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0),
      .dut_a(a0), .dut_b(b0), .dut_ci(ci0),
      .dut_s(s0), .dut_co(co0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err_cnt0), .fail_vec(fail_vec0)
   );

   task automatic run_main(output int cycles);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      cycles = 0;
      while (done !== 1'b1 && cycles < 6000) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      start   = 1'b0;
      start0  = 1'b0;
      mode    = 0;
      #1;
      checks++;
      if ({dut_a, dut_b, dut_ci} !== 9'd0) begin errors++; $display("FAIL reset_dut_io: got %0h want 0", {dut_a, dut_b, dut_ci}); end
      checks++;
      if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass}); end
      checks++;
      if (err_cnt !== 10'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      checks++;
      if (fail_vec !== 9'd0) begin errors++; $display("FAIL reset_fail_vec: got %0h want 0", fail_vec); end
      checks++;
      if (u_dut.vec !== 9'd0 || u_dut.settle_cnt !== 4'd0) begin errors++; $display("FAIL reset_counters: vec %0d settle %0d want 0 0", u_dut.vec, u_dut.settle_cnt); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || u_dut.state !== rca4_pkg::ST_IDLE) begin errors++; $display("FAIL idle_after_reset: busy %b state %0d want 0 0", busy, u_dut.state); end
   endtask

   task automatic test_clean_run;
      int cyc;
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_launch_cycle: got %b want 0", busy); end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_first_drive: got %b want 1", busy); end
      cyc = 1;
      while (done !== 1'b1 && cyc < 6000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc !== 2049) begin errors++; $display("FAIL clean_latency: got %0d want 2049", cyc); end
      checks++;
      if (pass !== 1'b1 || err_cnt !== 10'd0 || fail_vec !== 9'd0) begin errors++; $display("FAIL clean_result: pass %b err %0d fv %0h want 1 0 0", pass, err_cnt, fail_vec); end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if ({dut_a, dut_b, dut_ci} !== 9'h1FF || done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_hold: io %0h done %b busy %b want 1ff 1 0", {dut_a, dut_b, dut_ci}, done, busy); end
   endtask

   task automatic test_co_stuck;
      int cyc;
      mode = 1;
      run_main(cyc);
      checks++;
      if (cyc !== 2049) begin errors++; $display("FAIL co_stuck_latency: got %0d want 2049", cyc); end
      checks++;
      if (err_cnt !== 10'd256) begin errors++; $display("FAIL co_stuck_err_cnt: got %0d want 256", err_cnt); end
      checks++;
      if (fail_vec !== 9'h01F || pass !== 1'b0) begin errors++; $display("FAIL co_stuck_fail_vec: fv %0h pass %b want 1f 0", fail_vec, pass); end
   endtask

   task automatic test_s0_inverted;
      int cyc;
      mode = 2;
      run_main(cyc);
      checks++;
      if (err_cnt !== 10'd512) begin errors++; $display("FAIL s0_inv_err_cnt: got %0d want 512", err_cnt); end
      checks++;
      if (fail_vec !== 9'h000 || pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL s0_inv_result: fv %0h pass %b done %b want 0 0 1", fail_vec, pass, done); end
   endtask

   task automatic test_reset_mid_run;
      int cyc;
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      while ({dut_a, dut_b, dut_ci} !== 9'd100 && cyc < 6000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if ({dut_a, dut_b, dut_ci} !== 9'd100 || busy !== 1'b1) begin errors++; $display("FAIL reach_vec_100: io %0d busy %b want 100 1", {dut_a, dut_b, dut_ci}, busy); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({dut_a, dut_b, dut_ci} !== 9'd0 || {busy, done, pass} !== 3'b000) begin errors++; $display("FAIL async_reset_io: io %0h flags %b want 0 000", {dut_a, dut_b, dut_ci}, {busy, done, pass}); end
      checks++;
      if (err_cnt !== 10'd0 || fail_vec !== 9'd0 || u_dut.vec !== 9'd0) begin errors++; $display("FAIL async_reset_regs: err %0d fv %0h vec %0d want 0 0 0", err_cnt, fail_vec, u_dut.vec); end
      checks++;
      if (u_dut.state !== rca4_pkg::ST_IDLE) begin errors++; $display("FAIL async_reset_state: got %0d want 0", u_dut.state); end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stay_idle: busy %b done %b want 0 0", busy, done); end
      run_main(cyc);
      checks++;
      if (cyc !== 2049 || pass !== 1'b1 || err_cnt !== 10'd0) begin errors++; $display("FAIL rerun_after_reset: cyc %0d pass %b err %0d want 2049 1 0", cyc, pass, err_cnt); end
   endtask

   task automatic test_start_held;
      int cyc;
      mode = 2;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      cyc = 0;
      while (done !== 1'b1 && cyc < 6000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc !== 2049 || err_cnt !== 10'd512) begin errors++; $display("FAIL held_single_run: cyc %0d err %0d want 2049 512", cyc, err_cnt); end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || err_cnt !== 10'd0) begin errors++; $display("FAIL held_restart_clear: done %b err %0d want 0 0", done, err_cnt); end
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL held_restart_busy: got %b want 1", busy); end
      start = 1'b0;
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      mode = 0;
   endtask

   task automatic test_settle_zero;
      int cyc;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      cyc = 0;
      while (done0 !== 1'b1 && cyc < 6000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++;
      if (cyc !== 1025) begin errors++; $display("FAIL settle0_latency: got %0d want 1025", cyc); end
      checks++;
      if (pass0 !== 1'b1 || err_cnt0 !== 10'd0 || fail_vec0 !== 9'd0) begin errors++; $display("FAIL settle0_result: pass %b err %0d fv %0h want 1 0 0", pass0, err_cnt0, fail_vec0); end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_co_stuck();
      test_s0_inverted();
      test_reset_mid_run();
      test_start_held();
      test_settle_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
